// File: rtl/aes_key_expand_seq.sv
// Sequential AES key-schedule engine for AES-128/192/256.
// Produces one 32-bit schedule word per clock, packs groups of four words into
// 128-bit round keys 0..Nr and streams them out with a valid/ready handshake.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              begin expansion (sampled only while idle)
//   key_len            00=128, 01=192, 10=256, 11=invalid
//   key                cipher key, MSB-first (shorter keys use the upper bits)
//   abort              synchronous cancel back to idle
//   rk, rk_round       round key (w[4r] in [127:96]) and its index r
//   rk_valid, rk_ready round-key handshake
//   busy               high outside idle
//   done               one-cycle pulse after round Nr is accepted
//   err                one-cycle pulse on a rejected start
module aes_key_expand_seq #(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key,
  input  logic         abort,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [0:0] {StIdle, StGen} state_e;

  localparam bit Allow192 = (MAX_KEY_BITS >= 192);
  localparam bit Allow256 = (MAX_KEY_BITS >= 256);

  // Element 255 holds S(0x00), so the table is indexed with the inverted byte.
  localparam logic [255:0][7:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_e              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;       // schedule word index i
  logic [2:0]          pos_q, pos_d;       // i mod Nk
  logic [7:0]          rcon_q, rcon_d;
  logic [1:0]          klen_q, klen_d;
  logic [255:0]        key_q, key_d;       // shifts left one word per key-word emitted
  logic [7:0][31:0]    win_q, win_d;       // win[k] = w[i-1-k]
  logic [2:0][31:0]    acc_q, acc_d;       // first three words of the current group
  logic                fin_q, fin_d;       // all 4*(Nr+1) words generated
  logic [127:0]        rk_q, rk_d;
  logic [3:0]          round_q, round_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [5:0]  nk;
  logic [2:0]  nk_m1;
  logic [3:0]  nr;
  logic [5:0]  last_word;
  logic [31:0] w_prev, w_nk, sub_in, sub_out, w_new;
  logic        hs, stall, gen, len_ok;

  always_comb begin
    case (klen_q)
      2'b01: begin
        nk = 6'd6; nk_m1 = 3'd5; nr = 4'd12; last_word = 6'd51; w_nk = win_q[5];
      end
      2'b10: begin
        nk = 6'd8; nk_m1 = 3'd7; nr = 4'd14; last_word = 6'd59; w_nk = win_q[7];
      end
      default: begin
        nk = 6'd4; nk_m1 = 3'd3; nr = 4'd10; last_word = 6'd43; w_nk = win_q[3];
      end
    endcase

    case (key_len)
      2'b00:   len_ok = 1'b1;
      2'b01:   len_ok = Allow192;
      2'b10:   len_ok = Allow256;
      default: len_ok = 1'b0;
    endcase

    hs    = valid_q && rk_ready;
    stall = valid_q && !rk_ready;
    gen   = (state_q == StGen) && !abort && !fin_q && !stall;

    // One shared SubWord (four S-boxes); RotWord applied only on Nk boundaries.
    w_prev  = win_q[0];
    sub_in  = (pos_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = sub_word(sub_in);

    if (cnt_q < nk) begin
      w_new = key_q[255:224];
    end else if (pos_q == 3'd0) begin
      w_new = w_nk ^ sub_out ^ {rcon_q, 24'h0};
    end else if (klen_q == 2'b10 && pos_q == 3'd4) begin
      w_new = w_nk ^ sub_out;
    end else begin
      w_new = w_nk ^ w_prev;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    rcon_d  = rcon_q;
    klen_d  = klen_q;
    key_d   = key_q;
    win_d   = win_q;
    acc_d   = acc_q;
    fin_d   = fin_q;
    rk_d    = rk_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (len_ok) begin
            state_d = StGen;
            key_d   = key;
            klen_d  = key_len;
            cnt_d   = 6'd0;
            pos_d   = 3'd0;
            rcon_d  = 8'h01;
            fin_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StGen: begin
        if (abort) begin
          state_d = StIdle;
          valid_d = 1'b0;
          cnt_d   = 6'd0;
          fin_d   = 1'b0;
        end else begin
          if (hs) begin
            valid_d = 1'b0;
            if (round_q == nr) begin
              state_d = StIdle;
              done_d  = 1'b1;
              cnt_d   = 6'd0;
              fin_d   = 1'b0;
            end
          end
          if (gen) begin
            win_d = {win_q[6:0], w_new};
            key_d = {key_q[223:0], 32'h0};
            pos_d = (pos_q == nk_m1) ? 3'd0 : pos_q + 3'd1;
            if (cnt_q >= nk && pos_q == 3'd0) begin
              rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
            if (cnt_q == last_word) begin
              fin_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
            case (cnt_q[1:0])
              2'd0: acc_d[0] = w_new;
              2'd1: acc_d[1] = w_new;
              2'd2: acc_d[2] = w_new;
              default: begin
                rk_d    = {acc_q[0], acc_q[1], acc_q[2], w_new};
                round_d = cnt_q[5:2];
                valid_d = 1'b1;
              end
            endcase
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pos_q   <= '0;
      rcon_q  <= '0;
      klen_q  <= '0;
      key_q   <= '0;
      win_q   <= '0;
      acc_q   <= '0;
      fin_q   <= 1'b0;
      rk_q    <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      rcon_q  <= rcon_d;
      klen_q  <= klen_d;
      key_q   <= key_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      fin_q   <= fin_d;
      rk_q    <= rk_d;
      round_q <= round_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rk       = rk_q;
  assign rk_round = round_q;
  assign rk_valid = valid_q;
  assign busy     = (state_q == StGen);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
module tb_aes_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, start_s;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         abort;
  logic         rk_ready;
  logic [127:0] rk, rk_s;
  logic [3:0]   rk_round, rk_round_s;
  logic         rk_valid, rk_valid_s, busy, busy_s, done, done_s, err, err_s;

  always #5 clk = ~clk;

  aes_key_expand_seq dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key), .abort(abort),
    .rk(rk), .rk_round(rk_round), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .busy(busy), .done(done), .err(err)
  );

  aes_key_expand_seq #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .start(start_s), .key_len(key_len), .key(key), .abort(abort),
    .rk(rk_s), .rk_round(rk_round_s), .rk_valid(rk_valid_s), .rk_ready(rk_ready),
    .busy(busy_s), .done(done_s), .err(err_s)
  );

  localparam logic [255:0] K128A = {128'h000102030405060708090a0b0c0d0e0f,
                                    128'hfedcba9876543210fedcba9876543210};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                    64'hfedcba9876543210};
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KFIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                    128'h0123456789abcdef0123456789abcdef};

  // mode: 0 = rk_ready high, 1 = random backpressure, 2 = stray start mid-run
  typedef struct {
    logic [1:0]   kl;
    logic [255:0] k;
    int           mode;
    int           rnd;
    logic [127:0] exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;
  logic [127:0] got [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic int exp_keys(input logic [1:0] kl);
    case (kl)
      2'b01:   return 13;
      2'b10:   return 15;
      default: return 11;
    endcase
  endfunction

  // Starts one expansion and collects every handshaken round key into got[].
  task automatic run_expand(input logic [1:0] kl, input logic [255:0] kv, input int mode,
                            output int nk_out);
    logic         stall;
    logic [127:0] held_rk;
    logic [3:0]   held_r;
    bit           fin;
    int           nkeys;
    stall = 1'b0; fin = 1'b0; nkeys = 0; held_rk = '0; held_r = '0;
    for (int j = 0; j < 15; j++) got[j] = '0;
    @(negedge clk);
    key_len = kl; key = kv; start = 1'b1; rk_ready = 1'b1;
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      start = (mode == 2 && c == 10);
      if (mode == 2 && c == 10) begin
        key_len = 2'b10;
        key     = ~kv;
      end
      rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        chk("stall_valid", 128'(rk_valid), 128'(1));
        chk("stall_rk", rk, held_rk);
        chk("stall_round", 128'(rk_round), 128'(held_r));
      end
      if (rk_valid && rk_ready) begin
        chk("order", 128'(rk_round), 128'(nkeys));
        if (mode != 1) chk("timing", 128'(c), 128'(4 + 4 * nkeys));
        if (nkeys < 15) got[nkeys] = rk;
        nkeys++;
      end
      stall   = rk_valid && !rk_ready;
      held_rk = rk;
      held_r  = rk_round;
      if (done) begin
        fin = 1'b1;
        chk("busy_at_done", 128'(busy), 128'(0));
      end
    end
    chk("done_seen", 128'(fin), 128'(1));
    start = 1'b0;
    @(negedge clk);
    chk("idle_after", 128'({rk_valid, busy, done}), 128'(0));
    nk_out = nkeys;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           nk_run;
    logic [1:0]   pkl;
    logic [255:0] pk;
    int           pm;
    bit           found, saw_done;

    vecs[0]  = '{2'b00, K128A, 0, 0,  128'h000102030405060708090a0b0c0d0e0f};
    vecs[1]  = '{2'b00, K128A, 0, 1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
    vecs[2]  = '{2'b00, K128A, 0, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[3]  = '{2'b01, K192,  0, 0,  128'h000102030405060708090a0b0c0d0e0f};
    vecs[4]  = '{2'b01, K192,  0, 1,  128'h10111213141516175846f2f95c43f4fe};
    vecs[5]  = '{2'b01, K192,  0, 12, 128'ha4970a331a78dc09c418c271e3a41d5d};
    vecs[6]  = '{2'b10, K256,  0, 0,  128'h000102030405060708090a0b0c0d0e0f};
    vecs[7]  = '{2'b10, K256,  0, 1,  128'h101112131415161718191a1b1c1d1e1f};
    vecs[8]  = '{2'b10, K256,  0, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vecs[9]  = '{2'b00, KFIPS, 1, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vecs[10] = '{2'b00, KFIPS, 1, 1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[11] = '{2'b00, KFIPS, 1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[12] = '{2'b00, K128A, 2, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};

    rst = 1'b1; start = 1'b0; start_s = 1'b0; key_len = 2'b00; key = '0;
    abort = 1'b0; rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rk", rk, 128'(0));
    chk("rst_ctl", 128'({rk_round, rk_valid, busy, done, err}), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ctl", 128'({rk_round, rk_valid, busy, done, err}), 128'(0));

    // Invalid key_len on the full-size engine.
    key_len = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bad_len_err", 128'({err, busy}), 128'(2'b10));
    @(negedge clk);
    chk("bad_len_clear", 128'({err, busy}), 128'(0));

    // 128-bit-limited engine rejects 256 and 192, accepts 128.
    key_len = 2'b10; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("max128_256_err", 128'({err_s, busy_s}), 128'(2'b10));
    key_len = 2'b01; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("max128_192_err", 128'({err_s, busy_s}), 128'(2'b10));
    key_len = 2'b00; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    chk("max128_128_ok", 128'({err_s, busy_s}), 128'(2'b01));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("max128_abort", 128'(busy_s), 128'(0));

    pkl = '0; pk = '0; pm = -1;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].kl != pkl || vecs[i].k != pk || vecs[i].mode != pm) begin
        run_expand(vecs[i].kl, vecs[i].k, vecs[i].mode, nk_run);
        chk($sformatf("key_count_v%0d", i), 128'(nk_run), 128'(exp_keys(vecs[i].kl)));
        pkl = vecs[i].kl; pk = vecs[i].k; pm = vecs[i].mode;
      end
      chk($sformatf("vec%0d_r%0d", i, vecs[i].rnd), got[vecs[i].rnd], vecs[i].exp);
    end

    // Abort exactly when round 5 is offered (simultaneous handshake).
    @(negedge clk);
    key_len = 2'b00; key = K128A; start = 1'b1; rk_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (rk_valid && rk_round == 4'd5) found = 1'b1;
    end
    chk("abort_reach_r5", 128'(found), 128'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", 128'({busy, rk_valid, done}), 128'(0));
    saw_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || rk_valid || busy) saw_done = 1'b1;
    end
    chk("abort_quiet", 128'(saw_done), 128'(0));
    run_expand(2'b00, K128A, 0, nk_run);
    chk("abort_restart_r0", got[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("abort_restart_r10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Asynchronous reset while stalled in GEN.
    @(negedge clk);
    key_len = 2'b10; key = K256; start = 1'b1; rk_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", 128'({busy, rk_valid}), 128'(2'b11));
    chk("pre_rst_rk", rk, 128'h000102030405060708090a0b0c0d0e0f);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rk", rk, 128'(0));
    chk("async_rst_ctl", 128'({rk_round, rk_valid, busy, done, err}), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    run_expand(2'b10, K256, 0, nk_run);
    chk("rst_restart_count", 128'(nk_run), 128'(15));
    chk("rst_restart_r0", got[0], 128'h000102030405060708090a0b0c0d0e0f);
    chk("rst_restart_r14", got[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_seq.md
Name: aes_key_expand_seq

Overview:
Sequential AES key-schedule engine, the parametrised successor of the single-step combinational round-key block.
- Accepts an AES-128, AES-192 or AES-256 cipher key.
- Generates one 32-bit schedule word per clock using four internal S-box instances.
- Packs the words into 128-bit round keys 0..Nr and streams them out with a valid/ready handshake.
- Feeds the round pipeline or a round-key RAM in the cipher datapath.

Parameters:
- MAX_KEY_BITS, 256: largest key length supported (128, 192 or 256). A start requesting a longer key is rejected.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin expansion; sampled only in IDLE.
- key_len  in  2  00=128, 01=192, 10=256, 11=invalid.
- key  in  256  cipher key, MSB-first. 128-bit keys use key[255:128]; 192-bit keys use key[255:64].
- abort  in  1  synchronous cancel back to IDLE.
- rk  out  128  round key, word w[4r] in bits [127:96].
- rk_round  out  4  index r of rk.
- rk_valid  out  1  rk/rk_round valid.
- rk_ready  in  1  consumer accepts rk.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after round Nr is accepted.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. On rst, all of the following are 0: rk, rk_round, rk_valid, busy, done, err, the word counter and the key window. The FSM goes to IDLE.
- Key size: Nk = 4/6/8 and Nr = 10/12/14. Total words = 4*(Nr+1) = 44/52/60.
- States: IDLE and GEN.
- IDLE -> GEN on start when key_len is valid and its size is <= MAX_KEY_BITS.
  - In that cycle the key is latched and word counter i is set to 0.
  - busy goes high the next cycle.
- Invalid start (key_len=11, or size > MAX_KEY_BITS): err pulses the next cycle and the FSM stays in IDLE.
- GEN: each non-stalled cycle produces w[i] and increments i.
  - For i < Nk: w[i] = latched key word i.
  - Otherwise, with temp = w[i-1]:
    - if i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk],24'h0}.
    - else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
    - w[i] = w[i-Nk] ^ temp.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- Window: a shift register of the last 8 words supplies w[i-1] and w[i-Nk].
- Packing: words fill a 4-word accumulator. When the 4th word of group r is written, the registered rk, rk_round=r and rk_valid=1 appear on the following cycle.
- Timing with rk_ready held high:
  - start accepted at edge T0; words at T1..T4; rk_valid after T4 with r=0.
  - Subsequent round keys follow every 4 cycles.
- Backpressure: word generation stalls whenever rk_valid && !rk_ready. rk and rk_round stay stable until the handshake completes. rk_valid drops after the handshake unless a new group completes on that same edge.
- Completion: after the handshake of r = Nr, the FSM returns to IDLE and busy falls. done pulses in the cycle after that handshake.
- Counter boundary: the counter never exceeds total words minus 1, and no extra words are generated after w[4Nr+3].
- start while busy: ignored, with no effect on the key or counter.
- abort in GEN: next cycle the FSM is in IDLE; rk_valid, busy and the counter are cleared; no done pulse. abort takes priority over a simultaneous handshake.
- rst mid-operation: immediate clear, as on reset. The first start after reset behaves normally.

Test Plan:
- AES-128 with key 000102030405060708090A0B0C0D0E0F and rk_ready=1:
  - r0 = 000102030405060708090A0B0C0D0E0F.
  - r1 = D6AA74FDD2AF72FADAA678F1D6AB76FE.
  - r10 = 13111D7FE3944A17F307A78B4D2B30C5.
  - r0 appears 5 edges after start; keys thereafter every 4 cycles; done after r10.
- AES-192 with key 000102..17: r12 = A4970A331A78DC09C418C271E3A41D5D; 13 round keys total.
- AES-256 with key 000102..1F:
  - r1 = 101112131415161718191A1B1C1D1E1F.
  - r14 = 24FC79CCBF0979E9371AC23C6D68DE36.
  - Exercises the i mod 8 == 4 SubWord path.
- Backpressure, AES-128 key 2B7E151628AED2A6ABF7158809CF4F3C with rk_ready toggled randomly:
  - rk stable while stalled; no key lost or duplicated.
  - r10 = D014F9A8C9EE2589E13F0CC8B6630CA6.
- Control errors:
  - key_len=11 -> err pulse, busy stays 0.
  - MAX_KEY_BITS=128 with key_len=10 -> err pulse.
  - start while busy -> ignored; the sequence matches the unperturbed run.
- Abort and reset:
  - abort at r=5 -> next cycle IDLE, rk_valid=0, no done.
  - Async rst asserted mid-GEN -> outputs 0 immediately.
  - A restart after either produces the correct r0.
